cirno9_mem_arb: RTL and testbench

Parametrised N-channel arbiter that funnels load/store/fetch requests onto a single SRAM port.
It is the generalised successor of the core's fixed fetch/AG/slave memory mux, and sits between the fetch, AGU and bus-slave requesters and the on-chip SRAM.
It adds a selectable fixed-priority or round-robin mode, per-channel read-response routing and a sticky error flag.

---
 rtl/cirno9_mem_arb.sv | 105 ++++++++++
 tb/tb_cirno9_mem_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cirno9_mem_arb.sv
// cirno9_mem_arb: N-channel requester arbiter onto a single SRAM port.
// Fixed-priority or round-robin grant, 1-cycle read response routed back
// to the issuing channel, sticky read/write conflict flag.
module cirno9_mem_arb #(
  parameter int NCH  = 3,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        i_req_val,
  output logic [NCH-1:0]        o_req_rdy,
  input  logic [NCH*AW-1:0]     i_req_adr,
  input  logic [NCH*DW-1:0]     i_req_wdat,
  input  logic [NCH*DW/8-1:0]   i_req_wen,
  input  logic [NCH-1:0]        i_req_ren,
  output logic [NCH-1:0]        o_rsp_val,
  output logic [DW-1:0]         o_rsp_rdat,
  output logic                  o_sram_ren,
  output logic [DW/8-1:0]       o_sram_wen,
  output logic [AW-1:0]         o_adr,
  output logic [DW-1:0]         o_wdat,
  input  logic                  i_sram_rdy,
  input  logic [DW-1:0]         i_sram_rdat,
  output logic                  o_err
);

  localparam int PW = $clog2(NCH);
  localparam int BW = DW / 8;

  logic [PW-1:0]  ptr_q;
  logic [NCH-1:0] pend_q;
  logic           err_q;

  logic [NCH-1:0] rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_any;
  logic           hs;
  logic [AW-1:0]  sel_adr;
  logic [DW-1:0]  sel_wdat;
  logic [BW-1:0]  sel_wen;
  logic           sel_ren;
  logic           conflict;
  logic [PW-1:0]  ptr_next;

  // Grant selection: rotate the valid vector by the pointer (round-robin
  // only), take the lowest set bit, then rotate the offset back.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rot     = i_req_val;
    off     = '0;
    sum     = '0;
    gnt_idx = '0;
    if (MODE == 1) rot = NCH'({i_req_val, i_req_val} >> ptr_q);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    sum = {1'b0, off};
    if (MODE == 1) sum = {1'b0, ptr_q} + {1'b0, off};
    // Wrap with an explicit compare: NCH need not be a power of two.
    if (sum >= (PW+1)'(NCH)) gnt_idx = PW'(sum - (PW+1)'(NCH));
    else                     gnt_idx = sum[PW-1:0];
    // No grant is issued while reset is held so nothing strobes the SRAM.
    gnt_any = (|i_req_val) & ~rst;
  end

  // Channel mux, handshake and SRAM strobes for the granted channel.
  always_comb begin
    sel_adr   = i_req_adr[gnt_idx*AW +: AW];
    sel_wdat  = i_req_wdat[gnt_idx*DW +: DW];
    sel_wen   = i_req_wen[gnt_idx*BW +: BW];
    sel_ren   = i_req_ren[gnt_idx];
    hs        = gnt_any & i_sram_rdy;
    o_req_rdy = NCH'(hs) << gnt_idx;
    o_adr     = gnt_any ? sel_adr  : '0;
    o_wdat    = gnt_any ? sel_wdat : '0;
    o_sram_wen = hs ? sel_wen : '0;
    // A write wins over a simultaneous read; the read is dropped and flagged.
    o_sram_ren = hs & sel_ren & ~(|sel_wen);
    conflict   = hs & sel_ren & (|sel_wen);
    ptr_next   = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
  end

  // Pointer, pending-response and sticky-error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      pend_q <= o_sram_ren ? (NCH'(1) << gnt_idx) : '0;
      if (hs)       ptr_q <= ptr_next;
      if (conflict) err_q <= 1'b1;
    end
  end

  assign o_rsp_val  = pend_q;
  assign o_rsp_rdat = i_sram_rdat;
  assign o_err      = err_q;

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Directed bench for cirno9_mem_arb: one fixed-priority and one round-robin
// instance share the request inputs; a small SRAM model follows the
// round-robin instance.
module tb_cirno9_mem_arb;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0] req_val;
  logic [NCH-1:0] req_ren;
  logic [AW-1:0]  adr_c  [NCH];
  logic [DW-1:0]  wdat_c [NCH];
  logic [3:0]     wen_c  [NCH];
  logic           sram_rdy;
  logic [DW-1:0]  sram_rdat;

  logic [NCH*AW-1:0] req_adr;
  logic [NCH*DW-1:0] req_wdat;
  logic [NCH*4-1:0]  req_wen;
  assign req_adr  = {adr_c[2], adr_c[1], adr_c[0]};
  assign req_wdat = {wdat_c[2], wdat_c[1], wdat_c[0]};
  assign req_wen  = {wen_c[2], wen_c[1], wen_c[0]};

  logic [NCH-1:0] fp_rdy, fp_rsp, rr_rdy, rr_rsp;
  logic [DW-1:0]  fp_rdat, rr_rdat, fp_wdat, rr_wdat;
  logic [AW-1:0]  fp_adr, rr_adr;
  logic           fp_ren, rr_ren, fp_err, rr_err;
  logic [3:0]     fp_wen, rr_wen;

  cirno9_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .i_req_val(req_val), .o_req_rdy(fp_rdy),
    .i_req_adr(req_adr), .i_req_wdat(req_wdat), .i_req_wen(req_wen),
    .i_req_ren(req_ren), .o_rsp_val(fp_rsp), .o_rsp_rdat(fp_rdat),
    .o_sram_ren(fp_ren), .o_sram_wen(fp_wen), .o_adr(fp_adr),
    .o_wdat(fp_wdat), .i_sram_rdy(sram_rdy), .i_sram_rdat(sram_rdat),
    .o_err(fp_err)
  );

  cirno9_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .i_req_val(req_val), .o_req_rdy(rr_rdy),
    .i_req_adr(req_adr), .i_req_wdat(req_wdat), .i_req_wen(req_wen),
    .i_req_ren(req_ren), .o_rsp_val(rr_rsp), .o_rsp_rdat(rr_rdat),
    .o_sram_ren(rr_ren), .o_sram_wen(rr_wen), .o_adr(rr_adr),
    .o_wdat(rr_wdat), .i_sram_rdy(sram_rdy), .i_sram_rdat(sram_rdat),
    .o_err(rr_err)
  );

  // SRAM model: word-indexed by adr[7:0], read data one cycle after strobe.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h08] <= 32'h1234_5678;
      mem[8'h10] <= 32'h1111_1111;
      mem[8'h18] <= 32'h3333_3333;
      mem[8'h20] <= 32'h2222_2222;
      sram_rdat  <= '0;
    end else begin
      if (rr_ren) sram_rdat <= mem[rr_adr[7:0]];
      for (int b = 0; b < 4; b++)
        if (rr_wen[b]) mem[rr_adr[7:0]][8*b +: 8] <= rr_wdat[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_val = '0;
    req_ren = '0;
    for (int k = 0; k < NCH; k++) begin
      adr_c[k]  = '0;
      wdat_c[k] = '0;
      wen_c[k]  = '0;
    end
  endtask

  logic [NCH-1:0] exp_gnt [6];
  logic [DW-1:0]  exp_dat [6];

  initial begin
    idle_inputs();
    sram_rdy = 1'b1;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_dat = '{32'h1111_1111, 32'h3333_3333, 32'h2222_2222,
                32'h1111_1111, 32'h3333_3333, 32'h2222_2222};

    // Reset state
    step(); step();
    check("rst_rdy", rr_rdy, 3'b000);
    check("rst_rsp", rr_rsp, 3'b000);
    check("rst_ren", rr_ren, 1'b0);
    check("rst_wen", rr_wen, 4'h0);
    check("rst_err", rr_err, 1'b0);
    check("rst_adr", rr_adr, 32'h0);
    rst = 1'b0;
    step();

    // Fixed priority: ch0 and ch2 valid, ch0 first
    req_val = 3'b101; req_ren = 3'b101;
    adr_c[0] = 32'h10; adr_c[2] = 32'h20;
    #1;
    check("fp_rdy0", fp_rdy, 3'b001);
    check("fp_ren0", fp_ren, 1'b1);
    check("fp_adr0", fp_adr, 32'h10);
    check("rr_rdy0", rr_rdy, 3'b001);
    step();
    req_val = 3'b100; req_ren = 3'b100;
    #1;
    check("fp_rsp0", fp_rsp, 3'b001);
    check("fp_rdat0", fp_rdat, 32'h1111_1111);
    check("fp_adr2", fp_adr, 32'h20);
    check("fp_rdy2", fp_rdy, 3'b100);
    step();
    idle_inputs();
    #1;
    check("fp_rsp2", fp_rsp, 3'b100);
    check("fp_rdat2", fp_rdat, 32'h2222_2222);
    step();
    check("rsp_idle", rr_rsp, 3'b000);

    // Round-robin: all three valid for 6 cycles (pointer now 0)
    req_val = 3'b111; req_ren = 3'b111;
    adr_c[0] = 32'h10; adr_c[1] = 32'h18; adr_c[2] = 32'h20;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr_gnt%0d", c), rr_rdy, exp_gnt[c]);
      if (c > 0) begin
        check($sformatf("rr_rsp%0d", c), rr_rsp, exp_gnt[c-1]);
        check($sformatf("rr_rdat%0d", c), rr_rdat, exp_dat[c-1]);
      end
      step();
    end
    idle_inputs();
    #1;
    check("rr_rsp6", rr_rsp, 3'b100);
    check("rr_rdat6", rr_rdat, 32'h2222_2222);
    step();

    // Partial write on ch1 (pointer 0 -> ch1 granted)
    req_val = 3'b010; adr_c[1] = 32'h8; wdat_c[1] = 32'hAABB_CCDD; wen_c[1] = 4'b0011;
    #1;
    check("wr_wen", rr_wen, 4'b0011);
    check("wr_wdat", rr_wdat, 32'hAABB_CCDD);
    check("wr_adr", rr_adr, 32'h8);
    check("wr_ren", rr_ren, 1'b0);
    step();
    // Read back on ch0 (pointer 2, wraps to ch0)
    idle_inputs();
    req_val = 3'b001; req_ren = 3'b001; adr_c[0] = 32'h8;
    #1;
    check("wr_norsp", rr_rsp, 3'b000);
    check("rd8_gnt", rr_rdy, 3'b001);
    step();

    // SRAM stall with ch1 valid (pointer 1); pending ch0 response still lands
    idle_inputs();
    sram_rdy = 1'b0;
    req_val = 3'b010; req_ren = 3'b010; adr_c[1] = 32'h18;
    #1;
    check("rd8_rsp", rr_rsp, 3'b001);
    check("rd8_rdat", rr_rdat, 32'h1234_CCDD);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall_rdy%0d", c), rr_rdy, 3'b000);
      check($sformatf("stall_ren%0d", c), rr_ren, 1'b0);
      step();
    end
    check("stall_norsp", rr_rsp, 3'b000);
    sram_rdy = 1'b1;
    req_val = 3'b111; req_ren = 3'b111;
    adr_c[0] = 32'h10; adr_c[2] = 32'h20;
    #1;
    check("stall_gnt1", rr_rdy, 3'b010);
    check("stall_adr1", rr_adr, 32'h18);
    step();
    idle_inputs();
    #1;
    check("stall_rsp1", rr_rsp, 3'b010);
    check("stall_rdat1", rr_rdat, 32'h3333_3333);
    step();

    // Read/write conflict on ch2 (pointer 2)
    req_val = 3'b100; req_ren = 3'b100; adr_c[2] = 32'h30;
    wdat_c[2] = 32'hDEAD_BEEF; wen_c[2] = 4'hF;
    #1;
    check("cf_ren", rr_ren, 1'b0);
    check("cf_wen", rr_wen, 4'hF);
    check("cf_err_pre", rr_err, 1'b0);
    step();
    idle_inputs();
    #1;
    check("cf_err", rr_err, 1'b1);
    check("cf_err_fp", fp_err, 1'b1);
    check("cf_norsp", rr_rsp, 3'b000);
    for (int c = 0; c < 10; c++) step();
    check("cf_err_hold", rr_err, 1'b1);

    // Reset mid-operation (pointer 0): ch1 read, then reset before next edge
    req_val = 3'b010; req_ren = 3'b010; adr_c[1] = 32'h18;
    #1;
    check("mr_gnt", rr_rdy, 3'b010);
    step();
    rst = 1'b1;
    idle_inputs();
    #1;
    check("mr_rsp", rr_rsp, 3'b000);
    check("mr_err", rr_err, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("mr_rsp_after", rr_rsp, 3'b000);
    req_val = 3'b111; req_ren = 3'b111;
    adr_c[0] = 32'h10; adr_c[1] = 32'h18; adr_c[2] = 32'h20;
    #1;
    check("mr_ptr0", rr_rdy, 3'b001);
    step();
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
